// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: operand forwarding, load-use stall and redirect flush control
// for the decode stage. A DEPTH-entry shift register records the destination of
// every instruction that left decode; the operands of the decode instruction are
// matched against it to pick a forwarding source or raise a load-use stall.
//
// Ports:
//   clk, rst_n      core clock, synchronous active-low reset
//   dec_valid       dec_inst holds a real instruction
//   dec_inst        instruction in decode
//   redirect        X-stage taken branch/jump; decode is on the wrong path
//   dec_ready       decode may advance (combinational)
//   flush           kill the decode instruction (combinational)
//   fwd_a_sel       rs1 source: 0 = register file, k = result of entry k-1 (combinational)
//   fwd_b_sel       rs2 source, same encoding (combinational)
//   stall_cnt       cycles with dec_ready=0 (registered)
//   flush_cnt       cycles with flush=1 (registered)
module hazard_fwd_ctrl #(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32,
  localparam int unsigned SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [31:0]      dec_inst,
  input  logic             redirect,
  output logic             dec_ready,
  output logic             flush,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic             valid;
    logic             wen;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } trk_entry_t;

  trk_entry_t trk_q [DEPTH];
  trk_entry_t new_entry;

  logic [6:0]       opcode;
  logic [REG_W-1:0] dec_rd;
  logic [REG_W-1:0] dec_rs1;
  logic [REG_W-1:0] dec_rs2;
  logic             dec_wen;
  logic             dec_use_rs1;
  logic             dec_use_rs2;
  logic             dec_load;
  logic             dec_fire;
  logic             haz_a;
  logic             haz_b;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             unused_inst_bits;

  assign opcode  = dec_inst[6:0];
  assign dec_rd  = dec_inst[11:7];
  assign dec_rs1 = dec_inst[19:15];
  assign dec_rs2 = dec_inst[24:20];

  // funct7 and the low funct3 bits do not affect hazard decisions
  assign unused_inst_bits = ^{dec_inst[31:25], dec_inst[13:12]};

  // Decode classification: which instructions write rd and read rs1/rs2
  always_comb begin
    dec_wen     = 1'b0;
    dec_use_rs1 = 1'b0;
    dec_use_rs2 = 1'b0;
    dec_load    = 1'b0;
    case (opcode)
      7'h37, 7'h17, 7'h6F: dec_wen = 1'b1;
      7'h67, 7'h13: begin
        dec_wen     = 1'b1;
        dec_use_rs1 = 1'b1;
      end
      7'h03: begin
        dec_wen     = 1'b1;
        dec_use_rs1 = 1'b1;
        dec_load    = 1'b1;
      end
      7'h33: begin
        dec_wen     = 1'b1;
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
      end
      // SYSTEM: funct3[2]=1 is the immediate CSR form, rs1 field is a uimm
      7'h73: begin
        dec_wen     = 1'b1;
        dec_use_rs1 = ~dec_inst[14];
      end
      7'h63, 7'h23: begin
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  function automatic logic entry_hit(input trk_entry_t e, input logic [REG_W-1:0] rs);
    return e.valid && e.wen && (e.rd == rs) && (e.rd != '0);
  endfunction

  // Scan oldest to youngest so the youngest (lowest index) match is the one that sticks
  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    sel_a = '0;
    sel_b = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (dec_use_rs1 && entry_hit(trk_q[k], dec_rs1)) begin
        haz_a = trk_q[k].is_load && (k < int'(LOAD_LAT));
        sel_a = haz_a ? '0 : SEL_W'(k + 1);
      end
      if (dec_use_rs2 && entry_hit(trk_q[k], dec_rs2)) begin
        haz_b = trk_q[k].is_load && (k < int'(LOAD_LAT));
        sel_b = haz_b ? '0 : SEL_W'(k + 1);
      end
    end
  end

  // Redirect overrides a pending stall: the wrong-path instruction is dropped instead
  assign flush     = redirect & dec_valid;
  assign dec_ready = ~(dec_valid & (haz_a | haz_b) & ~redirect);
  assign dec_fire  = dec_valid & dec_ready & ~flush;
  assign fwd_a_sel = sel_a;
  assign fwd_b_sel = sel_b;

  // Entry written into the tracker this cycle; a bubble unless decode really advances
  always_comb begin
    new_entry = '0;
    if (dec_fire) begin
      new_entry.valid   = 1'b1;
      new_entry.wen     = dec_wen;
      new_entry.rd      = dec_rd;
      new_entry.is_load = dec_load;
    end
  end

  // In-flight tracker shift and performance counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        trk_q[k] <= '0;
      end
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      trk_q[0] <= new_entry;
      for (int k = 1; k < int'(DEPTH); k++) begin
        trk_q[k] <= trk_q[k-1];
      end
      if (!dec_ready) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
